cache_update_arb: RTL and testbench

//  Round-robin arbiter sharing the single cache_top update port (in_LBA / in_update_cache_2x)

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_rr_pick.sv | 31 +++
 rtl/cache_update_arb.sv | 135 +++++++++++++
 tb/tb_cache_update_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the cache update arbiter: default LBA width, arbiter FSM states
// and the gap counter width helper.
package cache_pkg;

    localparam int LBA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // A gap of zero still needs a one-bit counter so the register is never zero width.
    function automatic int cnt_width(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cache_rr_pick.sv
// Combinational round-robin picker: returns the first set request scanning upward
// from ptr+1 with wrap-around, as a one-hot grant, a binary index and an any flag.
module cache_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   index,
    output logic               any
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                index      = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_update_arb.sv
// Round-robin arbiter feeding the single cache_top update port, with a forced idle gap
// after each update. Optional duplicate-LBA filter: define CACHE_ARB_DUP_FILTER_EN.
module cache_update_arb
    import cache_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LBA_W      = LBA_W_DEF,
    parameter int GAP_CYCLES = 8
) (
    input  logic                     clk_2x,
    input  logic                     rst_2x,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*LBA_W-1:0] req_lba,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     out_update_cache_2x,
    output logic [LBA_W-1:0]         out_LBA,
    output logic                     busy,
    output logic                     dup_drop
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(GAP_CYCLES);

    arb_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [PTR_W-1:0]   ptr, ptr_n, pick_idx;
    logic [NUM_REQ-1:0] pick_grant, ack_n;
    logic               pick_any, strobe_n, dup_hit;
    logic [LBA_W-1:0]   lba_n, pick_lba;
    logic [LBA_W-1:0]   lba_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lba
        assign lba_arr[i] = req_lba[i*LBA_W +: LBA_W];
    end

    assign pick_lba = lba_arr[pick_idx];

    cache_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    // Requests arriving during ISSUE or GAP are not queued; they are simply re-seen in IDLE.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ptr_n    = ptr;
        ack_n    = '0;
        strobe_n = 1'b0;
        lba_n    = out_LBA;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = ISSUE;
                    ptr_n   = pick_idx;
                    ack_n   = pick_grant;
                    if (!dup_hit) begin
                        strobe_n = 1'b1;
                        lba_n    = pick_lba;
                    end
                end
            end
            ISSUE: begin
                if (dup_drop || GAP_CYCLES == 0) begin
                    state_n = IDLE;
                end else begin
                    state_n = GAP;
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_2x) begin
        if (rst_2x) begin
            state               <= IDLE;
            cnt                 <= '0;
            ptr                 <= PTR_W'(NUM_REQ - 1);
            req_ack             <= '0;
            out_update_cache_2x <= 1'b0;
            out_LBA             <= '0;
            busy                <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            ptr                 <= ptr_n;
            req_ack             <= ack_n;
            out_update_cache_2x <= strobe_n;
            out_LBA             <= lba_n;
            busy                <= (state_n != IDLE);
        end
    end

`ifdef CACHE_ARB_DUP_FILTER_EN
    logic [LBA_W-1:0] last_lba;
    logic             last_vld;
    logic             dup_q;

    assign dup_hit  = last_vld && (pick_lba == last_lba);
    assign dup_drop = dup_q;

    // last_lba tracks only LBAs actually sent to cache_top, never filtered ones.
    always_ff @(posedge clk_2x) begin
        if (rst_2x) begin
            last_lba <= '0;
            last_vld <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            dup_q <= (state == IDLE) && pick_any && dup_hit;
            if (strobe_n) begin
                last_lba <= lba_n;
                last_vld <= 1'b1;
            end
        end
    end
`else
    assign dup_hit  = 1'b0;
    assign dup_drop = 1'b0;
`endif

endmodule

// File: tb/tb_cache_update_arb.sv
// Directed bench for cache_update_arb: a GAP_CYCLES=4 instance and a GAP_CYCLES=0 instance
// sharing clock and reset, checked against hand-computed expectations.
module tb_cache_update_arb;

    localparam int NR = 4;
    localparam int LW = 32;

    logic              clk_2x    = 1'b0;
    logic              rst_2x    = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*LW-1:0]  req_lba   = '0;
    logic [NR-1:0]     req_ack;
    logic              out_update_cache_2x;
    logic [LW-1:0]     out_LBA;
    logic              busy;
    logic              dup_drop;

    logic [NR-1:0]     rv_z  = '0;
    logic [NR*LW-1:0]  lba_z = '0;
    logic [NR-1:0]     ack_z;
    logic              strobe_z;
    logic [LW-1:0]     olba_z;
    logic              busy_z;
    logic              dup_z;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_2x = ~clk_2x;

    cache_update_arb #(.NUM_REQ(NR), .LBA_W(LW), .GAP_CYCLES(4)) dut (
        .clk_2x              (clk_2x),
        .rst_2x              (rst_2x),
        .req_valid           (req_valid),
        .req_lba             (req_lba),
        .req_ack             (req_ack),
        .out_update_cache_2x (out_update_cache_2x),
        .out_LBA             (out_LBA),
        .busy                (busy),
        .dup_drop            (dup_drop)
    );

    cache_update_arb #(.NUM_REQ(NR), .LBA_W(LW), .GAP_CYCLES(0)) dut_z (
        .clk_2x              (clk_2x),
        .rst_2x              (rst_2x),
        .req_valid           (rv_z),
        .req_lba             (lba_z),
        .req_ack             (ack_z),
        .out_update_cache_2x (strobe_z),
        .out_LBA             (olba_z),
        .busy                (busy_z),
        .dup_drop            (dup_z)
    );

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk_2x);
        #1;
    endtask

    task automatic wait_strobe(input int max_steps, output int steps, output bit seen);
        steps = 0;
        seen  = 1'b0;
        while (!seen && steps < max_steps) begin
            step();
            steps++;
            if (out_update_cache_2x === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int max_steps, output bit ok);
        int steps;
        steps = 0;
        while (busy !== 1'b0 && steps < max_steps) begin
            step();
            steps++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_2x    = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({req_ack, out_update_cache_2x, out_LBA, busy, dup_drop} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs: got ack=%b stb=%b lba=%h busy=%b dup=%b expected all 0",
                         req_ack, out_update_cache_2x, out_LBA, busy, dup_drop);
            end
        end
        rst_2x = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (busy !== 1'b0 || req_ack !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL post_reset_idle: got busy=%b ack=%b expected busy=0 ack=0000", busy, req_ack);
            end
        end
    endtask

    task automatic test_single();
        req_lba[0 +: LW] = 32'h19860001;
        req_valid        = 4'b0001;
        step();
        vectors++;
        if (out_update_cache_2x !== 1'b1 || out_LBA !== 32'h19860001 || req_ack !== 4'b0001 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_issue: got stb=%b lba=%h ack=%b busy=%b expected 1 19860001 0001 1",
                     out_update_cache_2x, out_LBA, req_ack, busy);
        end
        // Requester keeps asking with a fresh LBA; it must wait out the gap.
        req_lba[0 +: LW] = 32'h19860002;
        for (int i = 2; i <= 7; i++) begin
            step();
            vectors++;
            if (out_update_cache_2x !== (i == 7) || (i <= 5 && busy !== 1'b1)) begin
                miscompares++;
                $display("[TB] FAIL gap_timing: t+%0d got stb=%b busy=%b expected stb=%b", i,
                         out_update_cache_2x, busy, (i == 7));
            end
        end
        vectors++;
        if (out_LBA !== 32'h19860002 || req_ack !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL second_issue: got lba=%h ack=%b expected 19860002 0001", out_LBA, req_ack);
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int  steps;
        bit  seen;
        int  order [3];
        int  exp_steps;
        rst_2x    = 1'b1;
        req_valid = '0;
        step();
        step();
        rst_2x = 1'b0;
        for (int i = 0; i < NR; i++) req_lba[i*LW +: LW] = 32'h10 + i;
        req_valid = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            exp_steps = (k == 0) ? 1 : 6;
            wait_strobe(12, steps, seen);
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("[TB] FAIL rr_timeout: grant %0d got no strobe expected one within 12 cycles", k);
            end else if (req_ack !== (4'b0001 << k) || out_LBA !== 32'h10 + k || steps != exp_steps) begin
                miscompares++;
                $display("[TB] FAIL rr_order: grant %0d got ack=%b lba=%h spacing=%0d expected ack=%b lba=%h spacing=%0d",
                         k, req_ack, out_LBA, steps, 4'b0001 << k, 32'h10 + k, exp_steps);
            end
            req_valid[k] = 1'b0;
        end
        // req1 alone moves the pointer to 1; then 0 and 2 together must go 2 then 0.
        order[0]  = 1;
        order[1]  = 2;
        order[2]  = 0;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(12, steps, seen);
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("[TB] FAIL rr_wrap_timeout: step %0d got no strobe expected one within 12 cycles", k);
            end else if (req_ack !== (4'b0001 << order[k]) || out_LBA !== 32'h10 + order[k] || steps != 6) begin
                miscompares++;
                $display("[TB] FAIL rr_wrap: step %0d got ack=%b lba=%h spacing=%0d expected ack=%b lba=%h spacing=6",
                         k, req_ack, out_LBA, steps, 4'b0001 << order[k], 32'h10 + order[k]);
            end
            req_valid[order[k]] = 1'b0;
            if (k == 0) req_valid = 4'b0101;
        end
        req_valid = '0;
    endtask

    task automatic test_gap_zero();
        bit exp;
        rv_z = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            lba_z[1*LW +: LW] = 32'hBEEF0000 + i;
            step();
            exp = (i % 2 == 0);
            vectors++;
            if (strobe_z !== exp || ack_z !== (exp ? 4'b0010 : 4'b0000) || busy_z !== exp ||
                (exp && olba_z !== 32'hBEEF0000 + i)) begin
                miscompares++;
                $display("[TB] FAIL gap_zero: cycle %0d got stb=%b ack=%b busy=%b lba=%h expected stb=%b",
                         i, strobe_z, ack_z, busy_z, olba_z, exp);
            end
        end
        rv_z = '0;
    endtask

    task automatic test_reset_abort();
        bit ok;
        wait_idle(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL abort_idle_timeout: got busy=%b expected 0", busy);
        end
        req_lba[0 +: LW] = 32'h00000055;
        req_valid        = 4'b0001;
        step();
        vectors++;
        if (out_update_cache_2x !== 1'b1 || req_ack !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL abort_setup: got stb=%b ack=%b expected 1 0001", out_update_cache_2x, req_ack);
        end
        req_valid = '0;
        step();
        rst_2x            = 1'b1;
        req_lba[3*LW +: LW] = 32'h00000033;
        req_valid         = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (busy !== 1'b0 || req_ack !== 4'b0000 || out_update_cache_2x !== 1'b0 || out_LBA !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL abort_in_gap: got busy=%b ack=%b stb=%b lba=%h expected 0 0000 0 00000000",
                         busy, req_ack, out_update_cache_2x, out_LBA);
            end
        end
        rst_2x = 1'b0;
        step();
        vectors++;
        if (req_ack !== 4'b1000 || out_update_cache_2x !== 1'b1 || out_LBA !== 32'h00000033) begin
            miscompares++;
            $display("[TB] FAIL grant_after_reset: got ack=%b stb=%b lba=%h expected 1000 1 00000033",
                     req_ack, out_update_cache_2x, out_LBA);
        end
        rst_2x    = 1'b1;
        req_valid = 4'b1001;
        step();
        rst_2x = 1'b0;
        step();
        vectors++;
        if (req_ack !== 4'b0001 || out_LBA !== 32'h00000055) begin
            miscompares++;
            $display("[TB] FAIL req0_first_after_reset: got ack=%b lba=%h expected 0001 00000055", req_ack, out_LBA);
        end
        req_valid = '0;
    endtask

    task automatic test_dup_filter();
        bit ok;
        wait_idle(20, ok);
        req_lba[1*LW +: LW] = 32'h07180001;
        req_valid           = 4'b0010;
        step();
        vectors++;
        if (out_update_cache_2x !== 1'b1 || req_ack !== 4'b0010 || out_LBA !== 32'h07180001) begin
            miscompares++;
            $display("[TB] FAIL dup_first: got stb=%b ack=%b lba=%h expected 1 0010 07180001",
                     out_update_cache_2x, req_ack, out_LBA);
        end
        req_valid = '0;
        wait_idle(20, ok);
        req_lba[2*LW +: LW] = 32'h07180001;
        req_valid           = 4'b0100;
        step();
        vectors++;
`ifdef CACHE_ARB_DUP_FILTER_EN
        if (req_ack !== 4'b0100 || dup_drop !== 1'b1 || out_update_cache_2x !== 1'b0 || out_LBA !== 32'h07180001) begin
            miscompares++;
            $display("[TB] FAIL dup_drop: got ack=%b dup=%b stb=%b lba=%h expected 0100 1 0 07180001",
                     req_ack, dup_drop, out_update_cache_2x, out_LBA);
        end
        req_valid = '0;
        step();
        vectors++;
        if (busy !== 1'b0 || dup_drop !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dup_no_gap: got busy=%b dup=%b expected 0 0", busy, dup_drop);
        end
`else
        if (req_ack !== 4'b0100 || dup_drop !== 1'b0 || out_update_cache_2x !== 1'b1 || out_LBA !== 32'h07180001) begin
            miscompares++;
            $display("[TB] FAIL repeat_lba_issue: got ack=%b dup=%b stb=%b lba=%h expected 0100 0 1 07180001",
                     req_ack, dup_drop, out_update_cache_2x, out_LBA);
        end
        req_valid = '0;
        wait_idle(20, ok);
`endif
        req_lba[3*LW +: LW] = 32'h07180002;
        req_valid           = 4'b1000;
        step();
        vectors++;
        if (out_update_cache_2x !== 1'b1 || req_ack !== 4'b1000 || out_LBA !== 32'h07180002 || dup_drop !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL new_lba_issue: got stb=%b ack=%b lba=%h dup=%b expected 1 1000 07180002 0",
                     out_update_cache_2x, req_ack, out_LBA, dup_drop);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gap_zero();
        test_reset_abort();
        test_dup_filter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "[TB] bench did not complete");
    end

endmodule
